// File: rtl/dense_layer_sequencer.sv
// Sequences one int8 fully-connected layer onto a shared external multiplier:
// dot product, bias, optional ReLU, fixed-point requantisation, int8 write-back.
module dense_layer_sequencer #(
  parameter int IN_AW  = 10,
  parameter int OUT_AW = 8,
  parameter int W_AW   = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [IN_AW-1:0]  i_n_in,
  input  logic [OUT_AW-1:0] i_n_out,
  input  logic [7:0]        i_zp_in,
  input  logic [7:0]        i_zp_w,
  input  logic [7:0]        i_zp_out,
  input  logic [31:0]       i_quant_mult,
  input  logic [4:0]        i_quant_shift,
  input  logic              i_relu_en,
  output logic              o_rd_en,
  output logic [IN_AW-1:0]  o_in_addr,
  output logic [W_AW-1:0]   o_w_addr,
  output logic [OUT_AW-1:0] o_b_addr,
  input  logic [7:0]        i_in_data,
  input  logic [7:0]        i_w_data,
  input  logic [31:0]       i_b_data,
  output logic [15:0]       o_mul_a,
  output logic [15:0]       o_mul_b,
  input  logic [31:0]       i_mul_p,
  output logic              o_out_we,
  output logic [OUT_AW-1:0] o_out_addr,
  output logic [7:0]        o_out_data,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_DRAIN1, S_DRAIN2, S_BIAS, S_REQ, S_WR, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [IN_AW-1:0]  n_in_q, k_cnt;
  logic [OUT_AW-1:0] n_out_q, neuron, b_addr;
  logic [W_AW-1:0]   w_cnt;
  logic [7:0]        zp_in_q, zp_w_q, zp_out_q, out_data_q;
  logic [31:0]       mult_q, acc, bias_q, bias_val;
  logic [4:0]        shift_q, req_t;
  logic              relu_q, rd_en;
  logic              mac_d1, mul_vld, bias_pend;
  logic [15:0]       mul_a_q, mul_b_q;
  logic signed [63:0] r64, m64, p64, rnd64, y64;

  // With n_in==0 there is no MAC cycle, so the bias read is issued in the
  // transition cycle (IDLE or WR) and its data lands exactly in BIAS.
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    b_addr   = neuron;
    case (state)
      S_IDLE: begin
        b_addr = '0;
        if (i_start) begin
          if (i_n_out == '0) begin
            state_nx = S_DONE;
          end else if (i_n_in == '0) begin
            state_nx = S_BIAS;
            rd_en    = 1'b1;
          end else begin
            state_nx = S_MAC;
          end
        end
      end
      S_MAC: begin
        rd_en = 1'b1;
        if (k_cnt == n_in_q - IN_AW'(1)) state_nx = S_DRAIN1;
      end
      S_DRAIN1: state_nx = S_DRAIN2;
      S_DRAIN2: state_nx = S_BIAS;
      S_BIAS:   state_nx = S_REQ;
      S_REQ:    state_nx = S_WR;
      S_WR: begin
        if (neuron == n_out_q - OUT_AW'(1)) begin
          state_nx = S_DONE;
        end else if (n_in_q == '0) begin
          state_nx = S_BIAS;
          rd_en    = 1'b1;
          b_addr   = neuron + OUT_AW'(1);
        end else begin
          state_nx = S_MAC;
        end
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign bias_val = bias_pend ? i_b_data : bias_q;

  // Requantisation: round-half-up by adding 1<<(t-1) before the arithmetic shift.
  always_comb begin
    req_t = 5'd31 - shift_q;
    r64   = (relu_q && acc[31]) ? 64'sd0 : {{32{acc[31]}}, acc};
    m64   = {{32{mult_q[31]}}, mult_q};
    rnd64 = 64'sd1 <<< (req_t - 5'd1);
    p64   = r64 * m64 + rnd64;
    y64   = p64 >>> req_t;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      n_in_q     <= '0;
      n_out_q    <= '0;
      zp_in_q    <= '0;
      zp_w_q     <= '0;
      zp_out_q   <= '0;
      mult_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      neuron     <= '0;
      k_cnt      <= '0;
      w_cnt      <= '0;
      acc        <= '0;
      bias_q     <= '0;
      bias_pend  <= 1'b0;
      mac_d1     <= 1'b0;
      mul_vld    <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      out_data_q <= '0;
    end else begin
      state     <= state_nx;
      mac_d1    <= rd_en && (state == S_MAC);
      bias_pend <= rd_en && ((state != S_MAC) || (k_cnt == '0));
      mul_vld   <= mac_d1;
      if (bias_pend) bias_q <= i_b_data;
      if (mac_d1) begin
        mul_a_q <= {{8{i_in_data[7]}}, i_in_data} - {{8{zp_in_q[7]}}, zp_in_q};
        mul_b_q <= {{8{i_w_data[7]}}, i_w_data} - {{8{zp_w_q[7]}}, zp_w_q};
      end
      if (mul_vld) acc <= acc + i_mul_p;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            n_in_q   <= i_n_in;
            n_out_q  <= i_n_out;
            zp_in_q  <= i_zp_in;
            zp_w_q   <= i_zp_w;
            zp_out_q <= i_zp_out;
            mult_q   <= i_quant_mult;
            shift_q  <= i_quant_shift;
            relu_q   <= i_relu_en;
            neuron   <= '0;
            k_cnt    <= '0;
            w_cnt    <= '0;
            acc      <= '0;
          end
        end
        S_MAC: begin
          k_cnt <= k_cnt + IN_AW'(1);
          w_cnt <= w_cnt + W_AW'(1);
        end
        S_BIAS: acc <= acc + bias_val;
        S_REQ:  out_data_q <= y64[7:0] + zp_out_q;
        S_WR: begin
          neuron <= neuron + OUT_AW'(1);
          k_cnt  <= '0;
          acc    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_en    = rd_en;
  assign o_in_addr  = k_cnt;
  assign o_w_addr   = w_cnt;
  assign o_b_addr   = b_addr;
  assign o_mul_a    = mul_a_q;
  assign o_mul_b    = mul_b_q;
  assign o_out_we   = (state == S_WR);
  assign o_out_addr = neuron;
  assign o_out_data = out_data_q;
  assign o_busy     = (state != S_IDLE);
  assign o_done     = (state == S_DONE);

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer: behavioural memories and an exact
// multiplier around the DUT, results checked against hand values and a layer model.
module tb_dense_layer_sequencer;

  logic        i_clk, i_rst, i_start;
  logic [9:0]  i_n_in;
  logic [7:0]  i_n_out, i_zp_in, i_zp_w, i_zp_out;
  logic [31:0] i_quant_mult;
  logic [4:0]  i_quant_shift;
  logic        i_relu_en;
  logic        o_rd_en;
  logic [9:0]  o_in_addr;
  logic [17:0] o_w_addr;
  logic [7:0]  o_b_addr;
  logic [7:0]  i_in_data, i_w_data;
  logic [31:0] i_b_data;
  logic [15:0] o_mul_a, o_mul_b;
  logic [31:0] i_mul_p;
  logic        o_out_we;
  logic [7:0]  o_out_addr, o_out_data;
  logic        o_busy, o_done;

  logic signed [7:0] in_mem [0:1023];
  logic signed [7:0] w_mem  [0:8191];
  int                b_mem  [0:255];
  logic [7:0]        wr_data [0:255];
  logic [7:0]        wr_addr_last;
  int  wr_cnt, done_cyc, start_cyc, cyc;
  int  checks, errors;
  logic signed [31:0] ma, mb;

  dense_layer_sequencer #(.IN_AW(10), .OUT_AW(8), .W_AW(18)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_n_in(i_n_in), .i_n_out(i_n_out),
    .i_zp_in(i_zp_in), .i_zp_w(i_zp_w), .i_zp_out(i_zp_out),
    .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift), .i_relu_en(i_relu_en),
    .o_rd_en(o_rd_en), .o_in_addr(o_in_addr), .o_w_addr(o_w_addr), .o_b_addr(o_b_addr),
    .i_in_data(i_in_data), .i_w_data(i_w_data), .i_b_data(i_b_data),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_p(i_mul_p),
    .o_out_we(o_out_we), .o_out_addr(o_out_addr), .o_out_data(o_out_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Exact 16x16 signed multiplier standing in for the shared core.
  assign ma = {{16{o_mul_a[15]}}, o_mul_a};
  assign mb = {{16{o_mul_b[15]}}, o_mul_b};
  assign i_mul_p = ma * mb;

  // Synchronous-read memories: data appears the cycle after the strobe.
  always @(posedge i_clk) begin
    if (o_rd_en) begin
      i_in_data <= in_mem[o_in_addr];
      i_w_data  <= w_mem[o_w_addr[12:0]];
      i_b_data  <= b_mem[o_b_addr];
    end
  end

  always @(negedge i_clk) begin
    if (o_out_we) begin
      wr_data[o_out_addr] = o_out_data;
      wr_addr_last = o_out_addr;
      wr_cnt = wr_cnt + 1;
    end
    if (o_done) done_cyc = cyc;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_out(input int n, input int n_in);
    int     acc;
    int     t;
    longint p;
    acc = 0;
    for (int k = 0; k < n_in; k++)
      acc += (int'(in_mem[k]) - int'($signed(i_zp_in))) *
             (int'(w_mem[n*n_in+k]) - int'($signed(i_zp_w)));
    acc += b_mem[n];
    if (i_relu_en && acc < 0) acc = 0;
    t = 31 - int'(i_quant_shift);
    p = longint'(acc) * longint'($signed(i_quant_mult)) + (longint'(1) << (t - 1));
    p = (p >>> t) + longint'($signed(i_zp_out));
    return p[7:0];
  endfunction

  // Configures one layer, pulses start (optionally a second, illegal start
  // during MAC with different sizes) and waits for o_done under a cycle budget.
  task automatic apply_stimulus(input int n_in, input int n_out,
                                input logic [7:0] zpi, input logic [7:0] zpw,
                                input logic [7:0] zpo, input logic [31:0] mult,
                                input logic [4:0] shift, input logic relu,
                                input bit poke);
    wr_cnt   = 0;
    done_cyc = -1;
    i_n_in = 10'(n_in); i_n_out = 8'(n_out);
    i_zp_in = zpi; i_zp_w = zpw; i_zp_out = zpo;
    i_quant_mult = mult; i_quant_shift = shift; i_relu_en = relu;
    i_start   = 1'b1;
    start_cyc = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
    if (poke) begin
      i_start = 1'b1; i_n_in = 10'd5; i_n_out = 8'd3;
      @(negedge i_clk);
      i_start = 1'b0; i_n_in = 10'(n_in); i_n_out = 8'(n_out);
    end
    for (int i = 0; i < 20000 && done_cyc < 0; i++) @(negedge i_clk);
    check_output("done_seen", 32'(done_cyc >= 0), 32'd1);
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    wr_cnt = 0; done_cyc = -1; wr_addr_last = '0;
    i_rst = 1'b1; i_start = 1'b0;
    i_n_in = '0; i_n_out = '0; i_zp_in = '0; i_zp_w = '0; i_zp_out = '0;
    i_quant_mult = '0; i_quant_shift = '0; i_relu_en = 1'b0;
    for (int k = 0; k < 1024; k++) in_mem[k] = '0;
    for (int k = 0; k < 8192; k++) w_mem[k] = '0;
    for (int k = 0; k < 256; k++) begin b_mem[k] = 0; wr_data[k] = '0; end
    repeat (3) @(negedge i_clk);
    check_output("rst_busy", 32'(o_busy), 32'd0);
    check_output("rst_done", 32'(o_done), 32'd0);
    check_output("rst_we", 32'(o_out_we), 32'd0);
    check_output("rst_rd", 32'(o_rd_en), 32'd0);
    check_output("rst_mul_a", 32'(o_mul_a), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    $display("[TB] basic two-input neuron");
    in_mem[0] = 8'sd3; in_mem[1] = 8'sd5; w_mem[0] = 8'sd2; w_mem[1] = -8'sd1; b_mem[0] = 10;
    apply_stimulus(2, 1, 8'h00, 8'h00, 8'h00, 32'h4000_0000, 5'd0, 1'b1, 1'b0);
    check_output("t1_writes", 32'(wr_cnt), 32'd1);
    check_output("t1_data", 32'(wr_data[0]), 32'h06);
    check_output("t1_addr", 32'(wr_addr_last), 32'd0);
    check_output("t1_done_cyc", 32'(done_cyc - start_cyc), 32'd8);

    $display("[TB] negative accumulator and relu");
    b_mem[0] = -5;
    apply_stimulus(2, 1, 8'h00, 8'h00, 8'h00, 32'h4000_0000, 5'd0, 1'b0, 1'b0);
    check_output("t2_neg", 32'(wr_data[0]), 32'hFE);
    apply_stimulus(2, 1, 8'h00, 8'h00, 8'h80, 32'h4000_0000, 5'd0, 1'b1, 1'b0);
    check_output("t2_relu_zp", 32'(wr_data[0]), 32'h80);

    $display("[TB] zero-point operand extremes");
    in_mem[0] = -8'sd128; w_mem[0] = 8'sd127; b_mem[0] = 0;
    apply_stimulus(1, 1, 8'h80, 8'hFF, 8'h00, 32'h4000_0000, 5'd0, 1'b0, 1'b0);
    check_output("t3_mul_a", 32'(o_mul_a), 32'h0000);
    check_output("t3_mul_b", 32'(o_mul_b), 32'h0080);
    check_output("t3_data", 32'(wr_data[0]), 32'h00);

    $display("[TB] start ignored while busy");
    in_mem[0] = 8'sd3; in_mem[1] = 8'sd5; w_mem[0] = 8'sd2; w_mem[1] = -8'sd1; b_mem[0] = 10;
    apply_stimulus(2, 1, 8'h00, 8'h00, 8'h00, 32'h4000_0000, 5'd0, 1'b1, 1'b1);
    check_output("t5_poke_writes", 32'(wr_cnt), 32'd1);
    check_output("t5_poke_data", 32'(wr_data[0]), 32'h06);
    check_output("t5_poke_done", 32'(done_cyc - start_cyc), 32'd8);

    $display("[TB] empty layer");
    apply_stimulus(4, 0, 8'h00, 8'h00, 8'h00, 32'h4000_0000, 5'd0, 1'b0, 1'b0);
    check_output("t5_nout0_done", 32'(done_cyc - start_cyc), 32'd1);
    check_output("t5_nout0_writes", 32'(wr_cnt), 32'd0);

    $display("[TB] bias-only neurons");
    b_mem[0] = 100; b_mem[1] = -300; b_mem[2] = 7;
    apply_stimulus(0, 3, 8'h00, 8'h00, 8'h00, 32'h4000_0000, 5'd2, 1'b0, 1'b0);
    check_output("t5_nin0_n0", 32'(wr_data[0]), 32'hC8);
    check_output("t5_nin0_n1", 32'(wr_data[1]), 32'hA8);
    check_output("t5_nin0_n2", 32'(wr_data[2]), 32'h0E);
    check_output("t5_nin0_done", 32'(done_cyc - start_cyc), 32'd10);

    $display("[TB] reset mid-layer then full 784x10 layer");
    for (int k = 0; k < 784; k++) in_mem[k] = 8'(k * 37 + 11);
    for (int j = 0; j < 7840; j++) w_mem[j] = 8'((j * 53 + 7) ^ (j >> 3));
    for (int n = 0; n < 10; n++) b_mem[n] = n * 1000 - 4000;
    wr_cnt = 0;
    i_n_in = 10'd784; i_n_out = 8'd10;
    i_zp_in = 8'h05; i_zp_w = 8'hFD; i_zp_out = 8'h0A;
    i_quant_mult = 32'h1234_5678; i_quant_shift = 5'd8; i_relu_en = 1'b1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int i = 0; i < 10000 && !(o_rd_en && o_b_addr == 8'd3 && o_in_addr == 10'd100); i++)
      @(negedge i_clk);
    check_output("t4_trigger", 32'(o_rd_en && o_b_addr == 8'd3 && o_in_addr == 10'd100), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_output("t4_busy_after_rst", 32'(o_busy), 32'd0);
    check_output("t4_we_after_rst", 32'(o_out_we), 32'd0);
    i_rst = 1'b0;
    repeat (20) @(negedge i_clk);
    check_output("t4_no_more_writes", 32'(wr_cnt), 32'd3);
    apply_stimulus(784, 10, 8'h05, 8'hFD, 8'h0A, 32'h1234_5678, 5'd8, 1'b1, 1'b0);
    check_output("t4_writes", 32'(wr_cnt), 32'd10);
    check_output("t4_done_cyc", 32'(done_cyc - start_cyc), 32'd7891);
    for (int n = 0; n < 10; n++)
      check_output($sformatf("t4_out%0d", n), 32'(wr_data[n]), 32'(model_out(n, 784)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
